// File: rtl/rgb_seq_pkg.sv
// Shared defaults for the RGB sequencer: 8-colour palette at 8-bit scale and width helpers.
// Pure constants and functions; no latency and no flow control.
package rgb_seq_pkg;

    localparam logic [23:0] DEFAULT_PALETTE [8] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
        24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h000000
    };

    function automatic int step_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Narrower widths keep the top bits; wider widths replicate the MSBs into the extra LSBs.
    function automatic logic [11:0] scale8(input logic [7:0] v, input int w);
        logic [15:0] rep;
        rep = {v, v};
        return 12'(rep >> (16 - w));
    endfunction

    function automatic logic [35:0] default_entry(input int idx, input int w);
        logic [23:0] c;
        logic [35:0] r, g, b;
        c = DEFAULT_PALETTE[idx];
        r = 36'(scale8(c[23:16], w));
        g = 36'(scale8(c[15:8], w));
        b = 36'(scale8(c[7:0], w));
        return (r << (2 * w)) | (g << w) | b;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One LED channel: duty register (crossfade stepper when RGB_SEQ_FADE_EN), compare, output flop.
// Compare-to-LED latency 1 cycle; no backpressure.
module rgb_pwm_channel #(
    parameter int PWM_W      = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [PWM_W-1:0] target,
    output logic             led
);
    localparam logic LED_OFF = (ACTIVE_LOW != 0);

    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] duty_nxt;
    logic [PWM_W-1:0] duty_eff;
    logic             boundary;
    logic             on;

    assign boundary = (pwm_cnt == '0);

    always_comb begin
`ifdef RGB_SEQ_FADE_EN
        duty_nxt = duty_q;
        if (duty_q < target)
            duty_nxt = duty_q + 1'b1;
        else if (duty_q > target)
            duty_nxt = duty_q - 1'b1;
`else
        duty_nxt = target;
`endif
    end

    // The boundary cycle already uses the new duty so a whole period sees one value.
    assign duty_eff = boundary ? duty_nxt : duty_q;
    assign on       = (pwm_cnt < duty_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            led    <= LED_OFF;
        end else begin
            if (boundary)
                duty_q <= duty_nxt;
            led <= on ^ LED_OFF;
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Steps an RGB LED through a writable palette, DWELL_CYCLES per entry; RGB_SEQ_FADE_EN adds crossfade.
// LEDs registered (1 cycle after compare); palette writes always accepted, no backpressure.
module rgb_pwm_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int PWM_W        = 8,
    parameter int NUM_STEPS    = 4,
    parameter int DWELL_CYCLES = 12000000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         wr_en,
    input  logic [step_w(NUM_STEPS)-1:0] wr_addr,
    input  logic [3*PWM_W-1:0]           wr_data,
    output logic                         red,
    output logic                         green,
    output logic                         blue,
    output logic [step_w(NUM_STEPS)-1:0] step,
    output logic                         step_tick
);
    localparam int SW = step_w(NUM_STEPS);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int EW = 3 * PWM_W;

    logic [PWM_W-1:0] pwm_cnt;
    logic [DW-1:0]    dwell;
    logic [EW-1:0]    palette [NUM_STEPS];
    logic [EW-1:0]    cur_entry;

    assign cur_entry = palette[step];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            dwell     <= '0;
            step      <= '0;
            step_tick <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            step_tick <= 1'b0;
            if (en) begin
                if (dwell == DW'(DWELL_CYCLES - 1)) begin
                    dwell     <= '0;
                    step_tick <= 1'b1;
                    step      <= (step == SW'(NUM_STEPS - 1)) ? '0 : step + 1'b1;
                end else begin
                    dwell <= dwell + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++)
                palette[i] <= EW'(default_entry(i, PWM_W));
        end else if (wr_en && (int'(wr_addr) < NUM_STEPS)) begin
            palette[wr_addr] <= wr_data;
        end
    end

    rgb_pwm_channel #(.PWM_W(PWM_W), .ACTIVE_LOW(ACTIVE_LOW)) u_red (
        .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt),
        .target(cur_entry[3*PWM_W-1 -: PWM_W]), .led(red)
    );

    rgb_pwm_channel #(.PWM_W(PWM_W), .ACTIVE_LOW(ACTIVE_LOW)) u_green (
        .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt),
        .target(cur_entry[2*PWM_W-1 -: PWM_W]), .led(green)
    );

    rgb_pwm_channel #(.PWM_W(PWM_W), .ACTIVE_LOW(ACTIVE_LOW)) u_blue (
        .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt),
        .target(cur_entry[PWM_W-1:0]), .led(blue)
    );

endmodule

// File: doc/rgb_pwm_sequencer.md
RGB_PWM_SEQUENCER -- requirements
Module: rgb_pwm_sequencer

Interface
REQ-001 SHALL have parameter PWM_W, default 8, duty/PWM counter width in bits (2..12).
REQ-002 SHALL have parameter NUM_STEPS, default 4, number of palette entries sequenced (2..8).
REQ-003 SHALL have parameter DWELL_CYCLES, default 12000000, clk cycles per step (>=2).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; when set, LED "on" drives 0.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1; 1 = advance steps, 0 = hold current step.
REQ-008 SHALL have port wr_en, input, 1, palette write strobe (single-cycle, no backpressure).
REQ-009 SHALL have port wr_addr, input, $clog2(NUM_STEPS), palette entry index.
REQ-010 SHALL have port wr_data, input, 3*PWM_W, {red,green,blue} duties, red in MSBs.
REQ-011 SHALL have ports red, green, blue, output, 1 each, registered LED drives.
REQ-012 SHALL have port step, output, $clog2(NUM_STEPS), index of the entry currently displayed.
REQ-013 SHALL have port step_tick, output, 1, one-cycle pulse on the cycle step changes.

Function
REQ-014 Free-running pwm_cnt (PWM_W bits) SHALL increment every cycle and wrap 2^PWM_W-1 -> 0.
REQ-015 A channel SHALL be on in a cycle iff pwm_cnt < active duty of that channel; duty 0 = always off, 2^PWM_W-1 = on 2^PWM_W-1 of 2^PWM_W cycles.
REQ-016 Outputs SHALL be registered: compare result appears on red/green/blue one cycle later, inverted when ACTIVE_LOW=1.
REQ-017 Active duties SHALL update only when pwm_cnt == 0 (period boundary), loaded from palette[step]; no mid-period glitch.
REQ-018 Dwell counter SHALL count 0..DWELL_CYCLES-1 while en=1; at terminal count it SHALL reset to 0, step SHALL advance, and step_tick SHALL pulse.
REQ-019 step SHALL wrap NUM_STEPS-1 -> 0.
REQ-020 en=0 SHALL freeze dwell counter and step; PWM SHALL continue on the current entry.
REQ-021 wr_en SHALL write wr_data into palette[wr_addr] at the clock edge; wr_addr >= NUM_STEPS SHALL be ignored.
REQ-022 Write to the currently displayed entry SHALL take effect at the next period boundary; a write coinciding with a step advance SHALL land in the palette and the new step reads the updated value.

Reset
REQ-023 On rst=1, asynchronously: pwm_cnt=0, dwell=0, step=0, step_tick=0, active duties=0, LEDs off (1 if ACTIVE_LOW, else 0).
REQ-024 On rst=1 the palette SHALL load the package default; release mid-sequence SHALL restart from step 0 with full dwell.

Configuration
REQ-025 Macro RGB_SEQ_FADE_EN defined: at each period boundary every active duty SHALL move by 1 toward its target palette[step] value (crossfade), holding once equal.
REQ-026 Macro RGB_SEQ_FADE_EN undefined: active duties SHALL jump directly to palette[step] at the period boundary; no fade logic synthesised.

Structure
REQ-027 Package rgb_seq_pkg SHALL hold the 8-entry default palette at 8-bit scale (red, green, blue, white, yellow, cyan, magenta, off), scaled to PWM_W by truncation/replication, and the step-index width function.
REQ-028 One sub-module rgb_pwm_channel (duty register, optional fade stepper, compare, output register) SHALL be instantiated three times.

Verification (PWM_W=4, NUM_STEPS=4, DWELL_CYCLES=32, ACTIVE_LOW=1)
REQ-029 Reset, en=1, no writes -> red low 15/16 cycles and green/blue high for step 0; step_tick after 32 cycles; steps 0,1,2,3,0 observed.
REQ-030 Write palette[1]=12'h080 during step 0 -> in step 1 green low exactly 8 of 16 cycles, red/blue always high.
REQ-031 Duty 0 and 15 entries -> LED never on / on 15 of 16 cycles; no glitch when written mid-period.
REQ-032 en=0 for 100 cycles at step 2 -> step stays 2, no step_tick, PWM continues; resume completes the remaining dwell.
REQ-033 rst asserted mid-step 3 -> outputs high immediately (async); after release, step=0 and palette restored to defaults.
REQ-034 With RGB_SEQ_FADE_EN, step 0->1 transition -> red duty decrements 15..0 and green increments 0..15, one per 16-cycle period.
